// File: rtl/vscale_dmem_responder_pkg.sv
// Shared encodings for the vscale data-memory responder: funct3 access sizes,
// responder states and the request-legality helpers used by the address-phase decode.
package vscale_dmem_responder_pkg;

    localparam logic [2:0] DMEM_SIZE_B  = 3'd0;
    localparam logic [2:0] DMEM_SIZE_H  = 3'd1;
    localparam logic [2:0] DMEM_SIZE_W  = 3'd2;
    localparam logic [2:0] DMEM_SIZE_BU = 3'd4;
    localparam logic [2:0] DMEM_SIZE_HU = 3'd5;

    typedef enum logic [1:0] {
        DRESP_IDLE = 2'd0,
        DRESP_BUSY = 2'd1,
        DRESP_ERR  = 2'd2
    } dresp_state_e;

    function automatic logic size_legal(input logic [2:0] size);
        case (size)
            DMEM_SIZE_B, DMEM_SIZE_H, DMEM_SIZE_W,
            DMEM_SIZE_BU, DMEM_SIZE_HU: size_legal = 1'b1;
            default:                    size_legal = 1'b0;
        endcase
    endfunction

    function automatic logic misaligned(input logic [2:0] size, input logic [1:0] byte_off);
        case (size)
            DMEM_SIZE_H, DMEM_SIZE_HU: misaligned = byte_off[0];
            DMEM_SIZE_W:               misaligned = |byte_off;
            default:                   misaligned = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/vscale_dmem_responder_lane_steer.sv
// Combinational byte-lane steering: store mask/data replication toward the word-wide
// memory, and load lane select with sign/zero extension back toward the core.
module vscale_dmem_lane_steer
    import vscale_dmem_responder_pkg::*;
(
    input  logic [2:0]  size,
    input  logic [1:0]  byte_off,
    input  logic [31:0] st_data,
    output logic [3:0]  st_mask,
    output logic [31:0] st_lanes,
    input  logic [31:0] ld_word,
    output logic [31:0] ld_data
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    always_comb begin
        st_mask  = 4'hF;
        st_lanes = st_data;
        // BU/HU share the B/H lane layout, so only the low two size bits matter here.
        case (size[1:0])
            2'b00: begin
                st_mask  = 4'b0001 << byte_off;
                st_lanes = {4{st_data[7:0]}};
            end
            2'b01: begin
                st_mask  = 4'b0011 << byte_off;
                st_lanes = {2{st_data[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        case (byte_off)
            2'd0:    ld_byte = ld_word[7:0];
            2'd1:    ld_byte = ld_word[15:8];
            2'd2:    ld_byte = ld_word[23:16];
            default: ld_byte = ld_word[31:24];
        endcase
        ld_half = byte_off[1] ? ld_word[31:16] : ld_word[15:0];

        case (size)
            DMEM_SIZE_B:  ld_data = {{24{ld_byte[7]}}, ld_byte};
            DMEM_SIZE_H:  ld_data = {{16{ld_half[15]}}, ld_half};
            DMEM_SIZE_BU: ld_data = {24'd0, ld_byte};
            DMEM_SIZE_HU: ld_data = {16'd0, ld_half};
            default:      ld_data = ld_word;
        endcase
    end

endmodule

// File: rtl/vscale_dmem_responder.sv
// Slave end of the vscale dmem port: address phase in DX is registered and served as a
// data phase in WB through a req/ready handshake, with misalign/range/timeout errors.
module vscale_dmem_responder
    import vscale_dmem_responder_pkg::*;
#(
    parameter int ADDR_WIDTH     = 16,
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_WIDTH      = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  dmem_en,
    input  logic                  dmem_wen,
    input  logic [2:0]            dmem_size,
    input  logic [31:0]           dmem_addr,
    input  logic [31:0]           dmem_wdata,
    output logic [31:0]           dmem_rdata,
    output logic                  dmem_wait,
    output logic                  dmem_badmem_e,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-3:0] mem_addr,
    output logic [3:0]            mem_wmask,
    output logic [31:0]           mem_wdata,
    input  logic [31:0]           mem_rdata,
    input  logic                  mem_ready
);

    localparam logic [CNT_WIDTH-1:0] TO_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

    dresp_state_e          state_q, state_d;
    logic                  wen_q, wen_d;
    logic [2:0]            size_q, size_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;

    logic        busy, timeout, accept, req_err;
    logic [3:0]  st_mask;
    logic [31:0] st_lanes, ld_data;

    vscale_dmem_lane_steer u_steer (
        .size     (size_q),
        .byte_off (addr_q[1:0]),
        .st_data  (dmem_wdata),
        .st_mask  (st_mask),
        .st_lanes (st_lanes),
        .ld_word  (mem_rdata),
        .ld_data  (ld_data)
    );

    always_comb begin
        busy    = (state_q == DRESP_BUSY);
        timeout = busy && (cnt_q == TO_LAST);

        // ready beats timeout when both land on the same cycle
        dmem_wait     = busy && !mem_ready && !timeout;
        dmem_badmem_e = (state_q == DRESP_ERR) || (timeout && !mem_ready);

        mem_req    = busy;
        mem_we     = busy && wen_q;
        mem_addr   = busy ? addr_q[ADDR_WIDTH-1:2] : '0;
        mem_wmask  = (busy && wen_q) ? st_mask : 4'd0;
        mem_wdata  = (busy && wen_q) ? st_lanes : 32'd0;
        dmem_rdata = (busy && mem_ready && !wen_q) ? ld_data : 32'd0;

        accept  = dmem_en && !dmem_wait;
        req_err = !size_legal(dmem_size) || misaligned(dmem_size, dmem_addr[1:0])
                  || (|dmem_addr[31:ADDR_WIDTH]);

        state_d = state_q;
        wen_d   = wen_q;
        size_d  = size_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;

        if (accept) begin
            wen_d   = dmem_wen;
            size_d  = dmem_size;
            addr_d  = dmem_addr[ADDR_WIDTH-1:0];
            cnt_d   = '0;
            state_d = req_err ? DRESP_ERR : DRESP_BUSY;
        end else if (!dmem_wait) begin
            cnt_d   = '0;
            state_d = DRESP_IDLE;
        end else begin
            cnt_d   = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= DRESP_IDLE;
            wen_q   <= 1'b0;
            size_q  <= 3'd0;
            addr_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            wen_q   <= wen_d;
            size_q  <= size_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule
